custom_apb_key_db: RTL and testbench

CUSTOM_APB_KEY_DB -- requirements
Module: custom_apb_key_db

---
 rtl/custom_apb_key_pkg.sv | 34 +++
 rtl/key_debounce.sv | 46 ++++
 rtl/custom_apb_key_db.sv | 95 +++++++++
 tb/tb_custom_apb_key_db.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/custom_apb_key_pkg.sv
// Shared register map and defaults for the APB key debouncer.
package custom_apb_key_pkg;

    localparam int unsigned OFF_DATA    = 'h00;
    localparam int unsigned OFF_RAW     = 'h04;
    localparam int unsigned OFF_DBCNT   = 'h08;
    localparam int unsigned OFF_INTEN   = 'h0C;
    localparam int unsigned OFF_INTSTAT = 'h10;
    localparam int unsigned OFF_ID      = 'h14;

    localparam int DB_RST_DEF = 1000;

    typedef enum logic [2:0] {
        REG_DATA,
        REG_RAW,
        REG_DBCNT,
        REG_INTEN,
        REG_INTSTAT,
        REG_ID,
        REG_NONE
    } reg_sel_e;

    // Word index is the APB address with the byte-lane bits dropped.
    function automatic reg_sel_e decode_reg(input logic [31:0] word_idx);
        if (word_idx == (OFF_DATA >> 2))         return REG_DATA;
        else if (word_idx == (OFF_RAW >> 2))     return REG_RAW;
        else if (word_idx == (OFF_DBCNT >> 2))   return REG_DBCNT;
        else if (word_idx == (OFF_INTEN >> 2))   return REG_INTEN;
        else if (word_idx == (OFF_INTSTAT >> 2)) return REG_INTSTAT;
        else if (word_idx == (OFF_ID >> 2))      return REG_ID;
        else                                     return REG_NONE;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchroniser, debounce counter and commit of the stable level.
module key_debounce
    import custom_apb_key_pkg::*;
#(
    parameter int DBW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           raw_in,
    input  logic [DBW-1:0] dbcnt,
    output logic           raw,
    output logic           data,
    output logic           rise
);

    logic           sync1;
    logic [DBW-1:0] cnt;
    logic           differ;
    logic           commit;

    // ">=" lets a counter left above a freshly lowered threshold commit at once.
    assign differ = raw ^ data;
    assign commit = differ && (cnt >= dbcnt);
    assign rise   = commit && raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            raw   <= 1'b0;
            data  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw_in;
            raw   <= sync1;
            if (!differ) begin
                cnt <= '0;
            end else if (commit) begin
                data <= raw;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/custom_apb_key_db.sv
// APB-attached multi-key debouncer with press interrupt (zero-wait-state slave).
module custom_apb_key_db
    import custom_apb_key_pkg::*;
#(
    parameter int ADDRWIDTH = 12,
    parameter int NKEYS     = 4,
    parameter int DBW       = 16,
    parameter int DB_RST    = DB_RST_DEF,
    parameter int KEY_POL   = 1
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 PSEL,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [31:0]          PWDATA,
    input  logic [3:0]           ECOREVNUM,
    output logic [31:0]          PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    input  logic [NKEYS-1:0]     keyIn,
    output logic                 KEYIRQ
);

    localparam logic [DBW-1:0] DBCNT_RST = DBW'(DB_RST);

    logic [NKEYS-1:0] key_act;
    logic [NKEYS-1:0] raw_vec;
    logic [NKEYS-1:0] data_vec;
    logic [NKEYS-1:0] rise_vec;
    logic [DBW-1:0]   dbcnt;
    logic [NKEYS-1:0] inten;
    logic [NKEYS-1:0] intstat;
    logic [NKEYS-1:0] clr_vec;
    logic [31:0]      word_idx;
    logic [31:0]      rd_val;
    reg_sel_e         sel;
    logic             rd_setup;
    logic             wr_en;
    logic             unused_bits;

    assign PREADY   = 1'b1;
    assign PSLVERR  = 1'b0;
    assign key_act  = (KEY_POL != 0) ? keyIn : ~keyIn;
    assign word_idx = 32'(PADDR[ADDRWIDTH-1:2]);
    assign sel      = decode_reg(word_idx);
    assign rd_setup = PSEL && !PWRITE && !PENABLE;
    assign wr_en    = PSEL && PENABLE && PWRITE;
    assign clr_vec  = (wr_en && (sel == REG_INTSTAT)) ? PWDATA[NKEYS-1:0] : '0;
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        key_debounce #(.DBW(DBW)) u_db (
            .clk    (PCLK),
            .rst_n  (PRESETn),
            .raw_in (key_act[i]),
            .dbcnt  (dbcnt),
            .raw    (raw_vec[i]),
            .data   (data_vec[i]),
            .rise   (rise_vec[i])
        );
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            REG_DATA:    rd_val[NKEYS-1:0] = data_vec;
            REG_RAW:     rd_val[NKEYS-1:0] = raw_vec;
            REG_DBCNT:   rd_val[DBW-1:0]   = dbcnt;
            REG_INTEN:   rd_val[NKEYS-1:0] = inten;
            REG_INTSTAT: rd_val[NKEYS-1:0] = intstat;
            REG_ID:      rd_val[3:0]       = ECOREVNUM;
            default:     rd_val            = '0;
        endcase
    end

    // A press landing on the same edge as its W1C wins over the clear.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PRDATA  <= '0;
            KEYIRQ  <= 1'b0;
            dbcnt   <= DBCNT_RST;
            inten   <= '0;
            intstat <= '0;
        end else begin
            if (rd_setup) PRDATA <= rd_val;
            if (wr_en && (sel == REG_DBCNT)) dbcnt <= PWDATA[DBW-1:0];
            if (wr_en && (sel == REG_INTEN)) inten <= PWDATA[NKEYS-1:0];
            intstat <= (intstat & ~clr_vec) | rise_vec;
            KEYIRQ  <= |(intstat & inten);
        end
    end

endmodule

// File: tb/tb_custom_apb_key_db.sv
// Bench for custom_apb_key_db: register table, directed timing cases and random run vs. a cycle model.
module tb_custom_apb_key_db;

    localparam int NK = 4;
    localparam logic [11:0] A_DATA = 12'h000, A_RAW = 12'h004, A_DBCNT = 12'h008,
                            A_INTEN = 12'h00C, A_INTSTAT = 12'h010, A_ID = 12'h014;
    localparam logic [3:0] ECO = 4'hA;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [3:0]  ECOREVNUM = ECO;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, KEYIRQ;
    logic [NK-1:0] keyIn = '0;

    int checks = 0;
    int errors = 0;

    custom_apb_key_db dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .ECOREVNUM(ECOREVNUM), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .keyIn(keyIn), .KEYIRQ(KEYIRQ)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [NK-1:0] m_s1 = '0, m_raw = '0, m_data = '0, m_inten = '0, m_intstat = '0;
    logic [NK-1:0] m_set, m_clr;
    int            m_run [NK];
    logic [15:0]   m_dbcnt = 16'd1000;
    logic          m_irq = 1'b0;
    logic [31:0]   m_prdata = '0;
    logic [31:0]   m_prd_n;
    logic          m_irq_n;

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a[11:2])
            10'd0:   return {28'b0, m_data};
            10'd1:   return {28'b0, m_raw};
            10'd2:   return {16'b0, m_dbcnt};
            10'd3:   return {28'b0, m_inten};
            10'd4:   return {28'b0, m_intstat};
            10'd5:   return {28'b0, ECO};
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < NK; i++) m_run[i] = 0;
        forever begin
            @(posedge PCLK or negedge PRESETn);
            if (!PRESETn) begin
                m_s1 = '0; m_raw = '0; m_data = '0; m_inten = '0; m_intstat = '0;
                m_dbcnt = 16'd1000; m_irq = 1'b0; m_prdata = '0;
                for (int i = 0; i < NK; i++) m_run[i] = 0;
            end else begin
                m_prd_n = (PSEL && !PWRITE && !PENABLE) ? m_read(PADDR) : m_prdata;
                m_irq_n = |(m_intstat & m_inten);
                m_set = '0;
                // A level change is accepted once it has been seen on more than DBCNT edges in a row.
                for (int i = 0; i < NK; i++) begin
                    if (m_raw[i] != m_data[i]) begin
                        if (m_run[i] + 1 > int'(m_dbcnt)) begin
                            m_data[i] = m_raw[i];
                            m_run[i]  = 0;
                            if (m_data[i]) m_set[i] = 1'b1;
                        end else begin
                            m_run[i] = m_run[i] + 1;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                m_clr = '0;
                if (PSEL && PENABLE && PWRITE) begin
                    case (PADDR[11:2])
                        10'd2:   m_dbcnt = PWDATA[15:0];
                        10'd3:   m_inten = PWDATA[NK-1:0];
                        10'd4:   m_clr   = PWDATA[NK-1:0];
                        default: ;
                    endcase
                end
                m_intstat = (m_intstat & ~m_clr) | m_set;
                m_raw     = m_s1;
                m_s1      = keyIn;
                m_prdata  = m_prd_n;
                m_irq     = m_irq_n;
            end
        end
    end

    // Continuous comparison of every observable output against the model.
    initial begin
        forever begin
            @(negedge PCLK);
            if (PRESETn === 1'b1) begin
                check("cyc_prdata", PRDATA, m_prdata);
                check("cyc_keyirq", {31'b0, KEYIRQ}, {31'b0, m_irq});
                check("cyc_pready", {30'b0, PREADY, PSLVERR}, 32'h2);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- APB helpers (all start and end on a falling edge) ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
        @(negedge PCLK);
        PENABLE = 1'b1;
        d = PRDATA;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        check(name, d, exp);
    endtask

    // Hold the read setup phase so PRDATA samples the register every cycle; n counts falling edges.
    task automatic poll(input logic [11:0] a, input int b, input logic v, input int maxc, output int n);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (PRDATA[b] !== v && n < maxc);
        PSEL = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [13];
    int   n;

    initial begin
        vecs[0]  = '{1'b0, A_DBCNT,   32'h0,        32'd1000,     "rst_dbcnt"};
        vecs[1]  = '{1'b0, A_ID,      32'h0,        {28'b0, ECO}, "rst_id"};
        vecs[2]  = '{1'b0, A_DATA,    32'h0,        32'h0,        "rst_data"};
        vecs[3]  = '{1'b0, A_RAW,     32'h0,        32'h0,        "rst_raw"};
        vecs[4]  = '{1'b0, A_INTSTAT, 32'h0,        32'h0,        "rst_intstat"};
        vecs[5]  = '{1'b0, A_INTEN,   32'h0,        32'h0,        "rst_inten"};
        vecs[6]  = '{1'b1, A_INTEN,   32'hFFFFFFFF, 32'hF,        "inten_zext"};
        vecs[7]  = '{1'b1, A_DBCNT,   32'hABCD1234, 32'h1234,     "dbcnt_zext"};
        vecs[8]  = '{1'b1, A_DATA,    32'hF,        32'h0,        "data_ro"};
        vecs[9]  = '{1'b1, A_ID,      32'h5,        {28'b0, ECO}, "id_ro"};
        vecs[10] = '{1'b1, 12'h018,   32'hFFFF,     32'h0,        "unmapped"};
        vecs[11] = '{1'b1, A_INTSTAT, 32'hF,        32'h0,        "intstat_w1c_idle"};
        vecs[12] = '{1'b1, A_INTEN,   32'h0,        32'h0,        "inten_clear"};

        idle(3);
        check("rst_prdata_async", PRDATA, 32'h0);
        check("rst_keyirq_async", {31'b0, KEYIRQ}, 32'h0);
        PRESETn = 1'b1;
        idle(1);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].wdata);
            read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end
        read_check("unmapped_high", 12'h800, 32'h0);

        // Press latency with DBCNT=3: short first press is also a glitch.
        apb_write(A_DBCNT, 32'd3);
        idle(3);
        keyIn[0] = 1'b1;
        poll(A_RAW, 0, 1'b1, 20, n);
        check("raw_latency", n, 3);
        keyIn[0] = 1'b0;
        idle(10);
        keyIn[0] = 1'b1;
        poll(A_DATA, 0, 1'b1, 40, n);
        check("data_latency", n, 7);
        read_check("intstat_press", A_INTSTAT, 32'h1);
        apb_write(A_INTSTAT, 32'h1);
        keyIn[0] = 1'b0;
        idle(10);

        // Three-cycle glitch on key 1 is rejected.
        keyIn[1] = 1'b1;
        idle(3);
        keyIn[1] = 1'b0;
        idle(10);
        read_check("glitch_data", A_DATA, 32'h0);
        read_check("glitch_intstat", A_INTSTAT, 32'h0);

        // Simultaneous presses and W1C of individual bits.
        apb_write(A_INTEN, 32'h5);
        keyIn = 4'b0101;
        idle(10);
        read_check("simul_intstat", A_INTSTAT, 32'h5);
        check("simul_irq", {31'b0, KEYIRQ}, 32'h1);
        apb_write(A_INTSTAT, 32'h1);
        read_check("w1c_bit0", A_INTSTAT, 32'h4);
        check("w1c_bit0_irq", {31'b0, KEYIRQ}, 32'h1);
        apb_write(A_INTSTAT, 32'h4);
        read_check("w1c_bit2", A_INTSTAT, 32'h0);
        check("w1c_bit2_irq", {31'b0, KEYIRQ}, 32'h0);
        keyIn = 4'b0000;
        idle(10);
        read_check("release_no_set", A_INTSTAT, 32'h0);

        // W1C landing on the very edge DATA[0] rises: set wins.
        keyIn[0] = 1'b1;
        idle(4);
        apb_write(A_INTSTAT, 32'h1);
        read_check("set_beats_clear", A_INTSTAT, 32'h1);
        apb_write(A_INTSTAT, 32'h1);
        keyIn[0] = 1'b0;
        idle(10);

        // Lowering DBCNT below an in-flight count commits on the next edge; DBCNT=0 tracks RAW.
        apb_write(A_DBCNT, 32'd100);
        keyIn[3] = 1'b1;
        idle(52);
        read_check("slow_not_yet", A_DATA, 32'h0);
        apb_write(A_DBCNT, 32'd10);
        poll(A_DATA, 3, 1'b1, 20, n);
        check("dbcnt_lowered", n, 2);
        apb_write(A_DBCNT, 32'd0);
        keyIn[3] = 1'b0;
        poll(A_DATA, 3, 1'b0, 20, n);
        check("dbcnt0_release", n, 4);
        keyIn[3] = 1'b1;
        poll(A_DATA, 3, 1'b1, 20, n);
        check("dbcnt0_press", n, 4);
        keyIn[3] = 1'b0;
        idle(5);
        apb_write(A_INTSTAT, 32'hF);

        // Random traffic; every cycle is compared against the model.
        fork
            begin
                for (int c = 0; c < 1500; c++) begin
                    @(negedge PCLK);
                    if ($urandom_range(0, 11) == 0) begin
                        int k;
                        k = $urandom_range(0, NK - 1);
                        keyIn[k] = ~keyIn[k];
                    end
                end
            end
            begin
                for (int t = 0; t < 450; t++) begin
                    int op;
                    logic [31:0] d;
                    op = $urandom_range(0, 9);
                    if (op <= 5) begin
                        apb_read((op == 5) ? 12'h400 : 12'(($urandom_range(0, 7)) << 2), d);
                    end else if (op == 6) begin
                        apb_write(A_DBCNT, $urandom_range(0, 6));
                    end else if (op == 7) begin
                        apb_write(A_INTEN, $urandom);
                    end else if (op == 8) begin
                        apb_write(A_INTSTAT, $urandom);
                    end else begin
                        idle($urandom_range(1, 4));
                    end
                end
            end
        join

        // Reset asserted mid-debounce.
        keyIn = '0;
        apb_write(A_DBCNT, 32'd20);
        apb_write(A_INTEN, 32'hF);
        idle(30);
        apb_write(A_INTSTAT, 32'hF);
        keyIn[1] = 1'b1;
        idle(30);
        check("pre_reset_irq", {31'b0, KEYIRQ}, 32'h1);
        keyIn[2] = 1'b1;
        idle(10);
        PRESETn = 1'b0;
        #1;
        check("mid_reset_irq", {31'b0, KEYIRQ}, 32'h0);
        check("mid_reset_prdata", PRDATA, 32'h0);
        idle(2);
        keyIn[1] = 1'b0;
        PRESETn = 1'b1;
        apb_write(A_DBCNT, 32'd3);
        poll(A_DATA, 2, 1'b1, 40, n);
        check("post_reset_count_from_zero", n, 5);
        read_check("post_reset_intstat", A_INTSTAT, 32'h4);
        read_check("post_reset_inten", A_INTEN, 32'h0);
        read_check("post_reset_dbcnt", A_DBCNT, 32'd3);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
